// File: rtl/axi4_stream_pkt_merge_if.sv
// axi4_stream_if: AXI4-Stream bundle with master/slave modports.
// Signals: tvalid, tready, tdata, tkeep, tstrb, tlast, tid, tdest, tuser.
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    logic                      tvalid;
    logic                      tready;
    logic [DATA_WIDTH-1:0]     tdata;
    logic [DATA_WIDTH/8-1:0]   tkeep;
    logic [DATA_WIDTH/8-1:0]   tstrb;
    logic                      tlast;
    logic [ID_WIDTH-1:0]       tid;
    logic [DEST_WIDTH-1:0]     tdest;
    logic [USER_WIDTH-1:0]     tuser;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axi4_stream_pkt_merge.sv
// axi4_stream_pkt_merge: rejoins split fragments into packed packets.
// Ports: clk_i, rst_i (async high), frag_size_i, pkt_i (slave),
//        pkt_o (master, one-beat register), oversize_o (pulse).
// Option: AXI4_STREAM_PKT_MERGE_TUSER_EOP_EN selects tuser[0] as the
//         final-fragment marker instead of the fragment size rule.
module axi4_stream_pkt_merge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 1,
    parameter int DEST_WIDTH     = 1,
    parameter int USER_WIDTH     = 1,
    parameter int MAX_PKT_SIZE_B = 2048,
    parameter int PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [PKT_SIZE_WIDTH:0] frag_size_i,
    axi4_stream_if.slave            pkt_i,
    axi4_stream_if.master           pkt_o,
    output logic                    oversize_o
);
    localparam int DWB = DATA_WIDTH / 8;
    localparam int CW  = $clog2(DWB) + 1;
    localparam int FW  = PKT_SIZE_WIDTH + 1;
    localparam int PW  = PKT_SIZE_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, MERGE, FINAL, FLUSH} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   res_data;
    logic [DWB-1:0]          res_keep;
    logic [DWB-1:0]          res_strb;
    logic [CW-1:0]           res_cnt;
    logic [FW-1:0]           frag_cnt;
    logic [FW-1:0]           size_q;
    logic [PW-1:0]           pkt_cnt;
    logic [ID_WIDTH-1:0]     id_q;
    logic [DEST_WIDTH-1:0]   dest_q;
    logic [USER_WIDTH-1:0]   user_q;

    logic                    in_fire;
    logic                    out_fire;
    logic                    first;
    logic [DWB-1:0]          in_mask;
    logic [DATA_WIDTH-1:0]   in_data;
    logic [CW-1:0]           n;
    logic [CW+2:0]           shift_b;
    logic [2*DATA_WIDTH-1:0] wide_data;
    logic [2*DWB-1:0]        wide_keep;
    logic [2*DWB-1:0]        wide_strb;
    logic [CW-1:0]           total;
    logic                    full;
    logic [FW-1:0]           frag_bytes;
    logic [FW-1:0]           size_eff;
    logic [PW-1:0]           pkt_total;
    logic                    last_frag;
    logic                    over;
    logic                    end_pkt;
    logic [ID_WIDTH-1:0]     sb_id;
    logic [DEST_WIDTH-1:0]   sb_dest;
    logic [USER_WIDTH-1:0]   sb_user;
    logic [USER_WIDTH-1:0]   user_mid;
    logic [USER_WIDTH-1:0]   user_end;

    function automatic logic [DWB-1:0] low_mask(input logic [CW-1:0] k);
        logic [DWB-1:0] m;
        for (int i = 0; i < DWB; i++) m[i] = (i < int'(k));
        return m;
    endfunction

    assign out_fire     = pkt_o.tvalid && pkt_o.tready;
    assign pkt_i.tready = (!pkt_o.tvalid || pkt_o.tready) && (state != FLUSH);
    assign in_fire      = pkt_i.tvalid && pkt_i.tready;
    // FINAL means the previous packet is closed; its successor may start now
    assign first        = (state == IDLE) || (state == FINAL);

    always_comb begin
        in_mask = pkt_i.tkeep | pkt_i.tstrb;
        n       = '0;
        in_data = '0;
        for (int i = 0; i < DWB; i++) begin
            n = n + CW'(in_mask[i]);
            if (in_mask[i]) in_data[8*i +: 8] = pkt_i.tdata[8*i +: 8];
        end
    end

    // New bytes land directly above the residual; both halves stay zero-padded
    assign shift_b   = {res_cnt, 3'b000};
    assign wide_data = {{DATA_WIDTH{1'b0}}, res_data}
                     | ({{DATA_WIDTH{1'b0}}, in_data} << shift_b);
    assign wide_keep = {{DWB{1'b0}}, res_keep}
                     | ({{DWB{1'b0}}, pkt_i.tkeep} << res_cnt);
    assign wide_strb = {{DWB{1'b0}}, res_strb}
                     | ({{DWB{1'b0}}, pkt_i.tstrb} << res_cnt);
    assign total     = res_cnt + n;
    assign full      = total >= CW'(DWB);

    assign frag_bytes = frag_cnt + FW'(n);
    assign size_eff   = first ? frag_size_i : size_q;
    assign pkt_total  = pkt_cnt + PW'(n);

`ifdef AXI4_STREAM_PKT_MERGE_TUSER_EOP_EN
    assign last_frag = pkt_i.tuser[0];
`else
    assign last_frag = (frag_bytes != size_eff);
`endif

    assign over    = !last_frag && (pkt_total >= PW'(MAX_PKT_SIZE_B));
    assign end_pkt = pkt_i.tlast && (last_frag || over);

    assign sb_id   = first ? pkt_i.tid   : id_q;
    assign sb_dest = first ? pkt_i.tdest : dest_q;
    assign sb_user = first ? pkt_i.tuser : user_q;

    always_comb begin
        user_mid = sb_user;
        user_end = sb_user;
`ifdef AXI4_STREAM_PKT_MERGE_TUSER_EOP_EN
        user_mid[0] = 1'b0;
        user_end[0] = 1'b1;
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            res_data     <= '0;
            res_keep     <= '0;
            res_strb     <= '0;
            res_cnt      <= '0;
            frag_cnt     <= '0;
            size_q       <= '0;
            pkt_cnt      <= '0;
            id_q         <= '0;
            dest_q       <= '0;
            user_q       <= '0;
            oversize_o   <= 1'b0;
            pkt_o.tvalid <= 1'b0;
            pkt_o.tlast  <= 1'b0;
            pkt_o.tdata  <= '0;
            pkt_o.tkeep  <= '0;
            pkt_o.tstrb  <= '0;
            pkt_o.tid    <= '0;
            pkt_o.tdest  <= '0;
            pkt_o.tuser  <= '0;
        end else begin
            oversize_o <= 1'b0;
            if (out_fire) pkt_o.tvalid <= 1'b0;

            if (state == FLUSH && out_fire) begin
                pkt_o.tvalid <= 1'b1;
                pkt_o.tlast  <= 1'b1;
                pkt_o.tdata  <= res_data;
                pkt_o.tkeep  <= low_mask(res_cnt);
                pkt_o.tstrb  <= res_strb;
                pkt_o.tuser  <= user_end;
                res_data     <= '0;
                res_keep     <= '0;
                res_strb     <= '0;
                res_cnt      <= '0;
                state        <= FINAL;
            end else if (state == FINAL && out_fire) begin
                state <= IDLE;
            end

            if (in_fire) begin
                if (first) begin
                    size_q <= frag_size_i;
                    id_q   <= pkt_i.tid;
                    dest_q <= pkt_i.tdest;
                    user_q <= pkt_i.tuser;
                end
                frag_cnt    <= pkt_i.tlast ? '0 : frag_bytes;
                pkt_cnt     <= end_pkt ? '0 : pkt_total;
                pkt_o.tid   <= sb_id;
                pkt_o.tdest <= sb_dest;

                if (full) begin
                    pkt_o.tvalid <= 1'b1;
                    pkt_o.tdata  <= wide_data[DATA_WIDTH-1:0];
                    pkt_o.tkeep  <= wide_keep[DWB-1:0];
                    pkt_o.tstrb  <= wide_strb[DWB-1:0];
                end

                if (end_pkt) begin
                    oversize_o <= over;
                    if (total > CW'(DWB)) begin
                        // Tail spills past one beat: full beat now, rest next
                        pkt_o.tlast <= 1'b0;
                        pkt_o.tuser <= user_mid;
                        res_data    <= wide_data[2*DATA_WIDTH-1:DATA_WIDTH];
                        res_keep    <= wide_keep[2*DWB-1:DWB];
                        res_strb    <= wide_strb[2*DWB-1:DWB];
                        res_cnt     <= total - CW'(DWB);
                        state       <= FLUSH;
                    end else begin
                        pkt_o.tvalid <= 1'b1;
                        pkt_o.tlast  <= 1'b1;
                        pkt_o.tdata  <= wide_data[DATA_WIDTH-1:0];
                        pkt_o.tkeep  <= low_mask(total);
                        pkt_o.tstrb  <= wide_strb[DWB-1:0] & low_mask(total);
                        pkt_o.tuser  <= user_end;
                        res_data     <= '0;
                        res_keep     <= '0;
                        res_strb     <= '0;
                        res_cnt      <= '0;
                        state        <= FINAL;
                    end
                end else begin
                    pkt_o.tlast <= 1'b0;
                    pkt_o.tuser <= user_mid;
                    state       <= MERGE;
                    if (full) begin
                        res_data <= wide_data[2*DATA_WIDTH-1:DATA_WIDTH];
                        res_keep <= wide_keep[2*DWB-1:DWB];
                        res_strb <= wide_strb[2*DWB-1:DWB];
                        res_cnt  <= total - CW'(DWB);
                    end else begin
                        res_data <= wide_data[DATA_WIDTH-1:0];
                        res_keep <= wide_keep[DWB-1:0];
                        res_strb <= wide_strb[DWB-1:0];
                        res_cnt  <= total;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_axi4_stream_pkt_merge.sv
// tb_axi4_stream_pkt_merge: directed fragment vectors for the merger.
// Expected beats, lengths and bytes are written out by hand per case.
module tb_axi4_stream_pkt_merge;
    localparam int DW   = 32;
    localparam int MAXB = 256;
    localparam int PSW  = $clog2(MAXB);

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [PSW:0]   frag_size;
    logic           oversize;

    always #5 clk = ~clk;

    axi4_stream_if #(.DATA_WIDTH(DW)) in_if ();
    axi4_stream_if #(.DATA_WIDTH(DW)) out_if ();

    axi4_stream_pkt_merge #(
        .DATA_WIDTH     (DW),
        .ID_WIDTH       (1),
        .DEST_WIDTH     (1),
        .USER_WIDTH     (1),
        .MAX_PKT_SIZE_B (MAXB)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .frag_size_i (frag_size),
        .pkt_i       (in_if),
        .pkt_o       (out_if),
        .oversize_o  (oversize)
    );

    beat_t      beat_q[$];
    beat_t      out_q[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] out_bytes[$];
    int         exp_lens[$];
    int         out_lens[$];
    int         cur_len;
    int         stall_cnt;
    int         ov_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         rdy_mode = 0;
    bit         rnd = 1'b0;
    logic [7:0] pay = 8'h00;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_all();
        beat_q.delete();
        out_q.delete();
        exp_bytes.delete();
        out_bytes.delete();
        exp_lens.delete();
        out_lens.delete();
        cur_len   = 0;
        stall_cnt = 0;
        ov_cnt    = 0;
    endtask

    task automatic add_frag(input int nb, input logic eop);
        beat_t b;
        int    k;
        for (int off = 0; off < nb; off += 4) begin
            k      = (nb - off < 4) ? nb - off : 4;
            b.data = 32'hEEEE_EEEE;
            for (int i = 0; i < k; i++) begin
                b.data[8*i +: 8] = rnd ? 8'($urandom) : pay;
                exp_bytes.push_back(b.data[8*i +: 8]);
                pay++;
            end
            b.keep = 4'((1 << k) - 1);
            b.last = (off + 4 >= nb);
            b.user = b.last && eop;
            beat_q.push_back(b);
        end
    endtask

    task automatic step();
        beat_t b;
        @(negedge clk);
        if (beat_q.size() > 0) begin
            in_if.tvalid = 1'b1;
            in_if.tdata  = beat_q[0].data;
            in_if.tkeep  = beat_q[0].keep;
            in_if.tstrb  = beat_q[0].keep;
            in_if.tlast  = beat_q[0].last;
            in_if.tuser  = beat_q[0].user;
        end else begin
            in_if.tvalid = 1'b0;
            in_if.tlast  = 1'b0;
        end
        case (rdy_mode)
            0:       out_if.tready = 1'b1;
            1:       out_if.tready = 1'($urandom_range(0, 1));
            default: out_if.tready = 1'b0;
        endcase
        #1;
        if (!in_if.tready) stall_cnt++;
        if (oversize) ov_cnt++;
        if (in_if.tvalid && in_if.tready) void'(beat_q.pop_front());
        if (out_if.tvalid && out_if.tready) begin
            b.data = out_if.tdata;
            b.keep = out_if.tkeep;
            b.last = out_if.tlast;
            b.user = out_if.tuser[0];
            out_q.push_back(b);
            for (int i = 0; i < 4; i++) begin
                if (out_if.tkeep[i]) begin
                    out_bytes.push_back(out_if.tdata[8*i +: 8]);
                    cur_len++;
                end
            end
            if (out_if.tlast) begin
                out_lens.push_back(cur_len);
                cur_len = 0;
            end
        end
    endtask

    task automatic run_idle(input string tag);
        int idle = 0;
        int c    = 0;
        while (idle < 4 && c < 6000) begin
            step();
            c++;
            if (beat_q.size() == 0 && !out_if.tvalid) idle++;
            else idle = 0;
        end
        check({tag, "_done"}, 64'(idle >= 4), 1);
    endtask

    task automatic expect_beat(input string tag, input int idx,
                               input logic [31:0] d, input logic [3:0] k,
                               input logic l);
        beat_t       b;
        logic [31:0] m;
        b = '0;
        if (idx < out_q.size()) b = out_q[idx];
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
        check({tag, "_data"}, b.data & m, d);
        check({tag, "_keep"}, b.keep, k);
        check({tag, "_last"}, b.last, l);
    endtask

    task automatic check_stream(input string tag);
        int mism = 0;
        int nl;
        int nb;
        check({tag, "_npkts"}, out_lens.size(), exp_lens.size());
        nl = (out_lens.size() < exp_lens.size()) ? out_lens.size()
                                                 : exp_lens.size();
        for (int i = 0; i < nl; i++)
            check($sformatf("%s_len%0d", tag, i), out_lens[i], exp_lens[i]);
        check({tag, "_nbytes"}, out_bytes.size(), exp_bytes.size());
        nb = (out_bytes.size() < exp_bytes.size()) ? out_bytes.size()
                                                   : exp_bytes.size();
        for (int i = 0; i < nb; i++)
            if (out_bytes[i] !== exp_bytes[i]) mism++;
        check({tag, "_bytes"}, mism, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_if.tvalid  = 1'b0;
        in_if.tdata   = '0;
        in_if.tkeep   = '0;
        in_if.tstrb   = '0;
        in_if.tlast   = 1'b0;
        in_if.tid     = '0;
        in_if.tdest   = '0;
        in_if.tuser   = '0;
        out_if.tready = 1'b1;
        frag_size     = 6;
        rst           = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_tvalid", out_if.tvalid, 0);
        check("rst_tlast", out_if.tlast, 0);
        check("rst_tdata", out_if.tdata, 0);
        check("rst_tkeep", out_if.tkeep, 0);
        check("rst_oversize", oversize, 0);
        check("rst_in_tready", in_if.tready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // fragments 6,6,2 -> packed beats, no stall
        clear_all();
        frag_size = 6;
        pay = 8'h00;
        add_frag(6, 1'b0);
        add_frag(6, 1'b0);
        add_frag(2, 1'b1);
        exp_lens.push_back(14);
        run_idle("t1");
        check("t1_nbeats", out_q.size(), 4);
        expect_beat("t1_b0", 0, 32'h0302_0100, 4'b1111, 1'b0);
        expect_beat("t1_b1", 1, 32'h0706_0504, 4'b1111, 1'b0);
        expect_beat("t1_b2", 2, 32'h0B0A_0908, 4'b1111, 1'b0);
        expect_beat("t1_b3", 3, 32'h0000_0D0C, 4'b0011, 1'b1);
        check("t1_stall", stall_cnt, 0);
        check("t1_oversize", ov_cnt, 0);
        check_stream("t1");

        // fragments 6,3 -> tail needs a second beat, one stall cycle
        clear_all();
        pay = 8'h00;
        add_frag(6, 1'b0);
        add_frag(3, 1'b1);
        exp_lens.push_back(9);
        run_idle("t2");
        check("t2_nbeats", out_q.size(), 3);
        expect_beat("t2_b0", 0, 32'h0302_0100, 4'b1111, 1'b0);
        expect_beat("t2_b1", 1, 32'h0706_0504, 4'b1111, 1'b0);
        expect_beat("t2_b2", 2, 32'h0000_0008, 4'b0001, 1'b1);
        check("t2_stall", stall_cnt, 1);
        check_stream("t2");

        // 33 full fragments of 8 hit the 256-byte cap after 32
        clear_all();
        frag_size = 8;
        pay = 8'h00;
        for (int i = 0; i < 33; i++) add_frag(8, 1'b0);
        add_frag(2, 1'b1);
        exp_lens.push_back(256);
        exp_lens.push_back(10);
        run_idle("t3");
        expect_beat("t3_cap", 63, 32'hFFFE_FDFC, 4'b1111, 1'b1);
        expect_beat("t3_tail", 66, 32'h0000_0908, 4'b0011, 1'b1);
        check("t3_oversize", ov_cnt, 1);
        check_stream("t3");

        // random backpressure, frag size 7, 20 packets
        clear_all();
        frag_size = 7;
        rdy_mode  = 1;
        rnd       = 1'b1;
        for (int p = 0; p < 20; p++) begin
            int len;
            int rem;
            len = $urandom_range(1, 200);
            while (len % 7 == 0) len = $urandom_range(1, 200);
            exp_lens.push_back(len);
            rem = len;
            while (rem > 7) begin
                add_frag(7, 1'b0);
                rem -= 7;
            end
            add_frag(rem, 1'b1);
        end
        run_idle("t4");
        check_stream("t4");
        check("t4_oversize", ov_cnt, 0);
        rnd      = 1'b0;
        rdy_mode = 0;

`ifdef AXI4_STREAM_PKT_MERGE_TUSER_EOP_EN
        // tuser[0] marks the end; equal-size fragments still close
        clear_all();
        frag_size = 4;
        pay = 8'h00;
        add_frag(4, 1'b0);
        add_frag(4, 1'b1);
        exp_lens.push_back(8);
        run_idle("t5");
        expect_beat("t5_b0", 0, 32'h0302_0100, 4'b1111, 1'b0);
        expect_beat("t5_b1", 1, 32'h0706_0504, 4'b1111, 1'b1);
        check("t5_user0", (out_q.size() > 0) ? out_q[0].user : 1'bx, 0);
        check("t5_user1", (out_q.size() > 1) ? out_q[1].user : 1'bx, 1);
        check_stream("t5");
`endif

        // reset mid-packet drops the partial packet
        clear_all();
        frag_size = 6;
        rdy_mode  = 2;
        pay = 8'h20;
        add_frag(6, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check("t6_pre_valid", out_if.tvalid, 1);
        @(negedge clk);
        rst = 1'b1;
        in_if.tvalid = 1'b0;
        #1;
        check("t6_rst_valid", out_if.tvalid, 0);
        check("t6_rst_tdata", out_if.tdata, 0);
        check("t6_rst_tkeep", out_if.tkeep, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_all();
        rdy_mode = 0;
        pay = 8'h30;
        add_frag(2, 1'b1);
        exp_lens.push_back(2);
        run_idle("t6");
        check("t6_nbeats", out_q.size(), 1);
        expect_beat("t6_b0", 0, 32'h0000_3130, 4'b0011, 1'b1);
        check_stream("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
